// File: rtl/fifo_pkg.sv
// Shared FIFO/serializer widths and drain-stage state encoding.
// Pure declarations, no logic.
// Keeps the FIFO model and its drain stage agreeing on word geometry.
package fifo_pkg;

    localparam int FWIDTH  = 32;
    localparam int FDEPTH  = 16;
    localparam int FCWIDTH = $clog2(FDEPTH) + 1;
    localparam int BWIDTH  = 8;
    localparam int NBYTES  = FWIDTH / BWIDTH;
    localparam int IDXW    = $clog2(NBYTES);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_e;

endpackage

// File: rtl/fifo_byte_serializer_if.sv
// FIFO read port plus byte-wide valid/ready link of the drain stage.
// No logic; master = serializer, slave = FIFO and byte sink.
// Flow control: Byte_Valid/Byte_Ready on the link, FOutN strobe on the FIFO.
interface fifo_byte_serializer_if;
    import fifo_pkg::*;

    logic [FWIDTH-1:0] F_Data;
    logic              F_EmptyN;
    logic              FOutN;
    logic [BWIDTH-1:0] Byte_Out;
    logic              Byte_Valid;
    logic              Byte_Ready;
    logic              Last_Byte;

    modport master (
        input  F_Data, F_EmptyN, Byte_Ready,
        output FOutN, Byte_Out, Byte_Valid, Last_Byte
    );

    modport slave (
        output F_Data, F_EmptyN, Byte_Ready,
        input  FOutN, Byte_Out, Byte_Valid, Last_Byte
    );

endinterface

// File: rtl/fifo_ser_shreg.sv
// Word holding register with byte index; presents the indexed byte, LSB first.
// Latency: byte visible the cycle after Load.
// Backpressure: index only moves on Advance, so the byte holds otherwise.
module fifo_ser_shreg
    import fifo_pkg::*;
(
    input  logic              Clk,
    input  logic              RstN,
    input  logic              Load,
    input  logic              Advance,
    input  logic              Clear,
    input  logic [FWIDTH-1:0] LoadData,
    output logic [BWIDTH-1:0] ByteOut,
    output logic              LastFlag
);

    logic [FWIDTH-1:0] shReg;
    logic [IDXW-1:0]   idx;

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            shReg <= '0;
            idx   <= '0;
        end else if (Clear) begin
            shReg <= '0;
            idx   <= '0;
        end else if (Load) begin
            shReg <= LoadData;
            idx   <= '0;
        end else if (Advance) begin
            idx <= idx + 1'b1;
        end
    end

    assign ByteOut  = shReg[idx*BWIDTH +: BWIDTH];
    assign LastFlag = (idx == IDXW'(NBYTES - 1));

endmodule

// File: rtl/fifo_byte_serializer.sv
// Pops 32-bit words from the FIFO and streams them LSB byte first.
// Latency: pop cycle N, byte 0 valid cycle N+1; back-to-back words without bubbles.
// Backpressure: Byte_Ready low freezes byte, index and state; no pop is issued.
module fifo_byte_serializer
    import fifo_pkg::*;
(
    input  logic                     Clk,
    input  logic                     RstN,
    input  logic                     FClrN,
    input  logic                     Enable,
    fifo_byte_serializer_if.master   bus,
    output logic                     Busy,
    output logic [15:0]              Word_Cnt
);

    localparam logic [0:0] ST_IDLE = IDLE;
    localparam logic [0:0] ST_SEND = SEND;

    logic [0:0] state;
    logic       sendVld;
    logic       lastIdx;
    logic       xfer;
    logic       lastXfer;
    logic       pop;

    assign sendVld  = (state == ST_SEND);
    assign xfer     = sendVld & bus.Byte_Ready;
    assign lastXfer = xfer & lastIdx;

    // RstN gates the strobe so the FIFO never sees a pop while held in reset.
    assign pop = RstN & FClrN & Enable & bus.F_EmptyN & ((state == ST_IDLE) | lastXfer);

    assign bus.FOutN      = ~pop;
    assign bus.Byte_Valid = sendVld;
    assign bus.Last_Byte  = sendVld & lastIdx;
    assign Busy           = sendVld;

    fifo_ser_shreg uShreg (
        .Clk      (Clk),
        .RstN     (RstN),
        .Load     (pop),
        .Advance  (xfer & ~lastIdx & FClrN),
        .Clear    (~FClrN),
        .LoadData (bus.F_Data),
        .ByteOut  (bus.Byte_Out),
        .LastFlag (lastIdx)
    );

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            state <= ST_IDLE;
        end else if (!FClrN) begin
            state <= ST_IDLE;
        end else if (pop) begin
            state <= ST_SEND;
        end else if (lastXfer) begin
            state <= ST_IDLE;
        end
    end

    // A final byte accepted in a clear cycle still counts as a finished word.
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            Word_Cnt <= '0;
        end else if (lastXfer) begin
            Word_Cnt <= Word_Cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_fifo_byte_serializer.sv
// Directed bench for fifo_byte_serializer with a behavioural 16-entry FIFO in front.
module tb_fifo_byte_serializer;

    logic        Clk = 1'b0;
    logic        RstN;
    logic        FClrN;
    logic        Enable;
    logic        Busy;
    logic [15:0] Word_Cnt;

    fifo_byte_serializer_if bus ();

    fifo_byte_serializer dut (
        .Clk      (Clk),
        .RstN     (RstN),
        .FClrN    (FClrN),
        .Enable   (Enable),
        .bus      (bus),
        .Busy     (Busy),
        .Word_Cnt (Word_Cnt)
    );

    always #5 Clk = ~Clk;

    // FIFO model: data valid combinationally at the read pointer
    logic [31:0] mem [16];
    int          wrPtr = 0;
    int          rdPtr = 0;

    assign bus.F_Data   = mem[rdPtr % 16];
    assign bus.F_EmptyN = (wrPtr != rdPtr);

    always @(posedge Clk) begin
        if (!FClrN)          rdPtr <= wrPtr;
        else if (!bus.FOutN) rdPtr <= rdPtr + 1;
    end

    // Link monitor, sampled mid-cycle
    int         cyc = 0;
    logic [7:0] capB [$];
    logic       capL [$];
    int         capC [$];
    int         popCnt = 0;
    int         popAtLast = 0;

    always @(posedge Clk) cyc <= cyc + 1;

    always @(negedge Clk) begin
        if (RstN) begin
            if (bus.Byte_Valid && bus.Byte_Ready) begin
                capB.push_back(bus.Byte_Out);
                capL.push_back(bus.Last_Byte);
                capC.push_back(cyc);
            end
            if (!bus.FOutN) begin
                popCnt = popCnt + 1;
                if (bus.Last_Byte && bus.Byte_Ready) popAtLast = popAtLast + 1;
            end
        end
    end

    int checks = 0;
    int errors = 0;
    int expWc  = 0;

    task automatic push(input logic [31:0] w);
        mem[wrPtr % 16] = w;
        wrPtr = wrPtr + 1;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic wait_byte(input logic [7:0] b, input string name);
        bit found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(posedge Clk); #1;
            if (bus.Byte_Valid && bus.Byte_Out == b) found = 1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL %s: byte %h never presented within 60 cycles", name, b);
        end
    endtask

    task automatic test_reset;
        RstN = 1'b0; FClrN = 1'b1; Enable = 1'b1; bus.Byte_Ready = 1'b1;
        cycles(3);
        checks += 6;
        if (bus.FOutN !== 1'b1)      begin errors++; $display("FAIL rst_foutn: got %b want 1", bus.FOutN); end
        if (bus.Byte_Valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", bus.Byte_Valid); end
        if (bus.Last_Byte !== 1'b0)  begin errors++; $display("FAIL rst_last: got %b want 0", bus.Last_Byte); end
        if (Busy !== 1'b0)           begin errors++; $display("FAIL rst_busy: got %b want 0", Busy); end
        if (bus.Byte_Out !== 8'h00)  begin errors++; $display("FAIL rst_byte: got %h want 00", bus.Byte_Out); end
        if (Word_Cnt !== 16'd0)      begin errors++; $display("FAIL rst_wcnt: got %0d want 0", Word_Cnt); end
        RstN = 1'b1;
        cycles(2);
    endtask

    task automatic test_single;
        logic [7:0] e [4] = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
        logic       el [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        int m = capB.size();
        int p = popCnt;
        push(32'hA1B2C3D4);
        @(negedge Clk);
        checks += 2;
        if (bus.FOutN !== 1'b0)      begin errors++; $display("FAIL single_pop_now: FOutN %b want 0", bus.FOutN); end
        if (bus.Byte_Valid !== 1'b0) begin errors++; $display("FAIL single_lat_pop: valid %b want 0", bus.Byte_Valid); end
        @(negedge Clk);
        checks += 2;
        if (bus.Byte_Valid !== 1'b1 || bus.Byte_Out !== 8'hD4)
            begin errors++; $display("FAIL single_lat_byte0: valid %b byte %h want 1 d4", bus.Byte_Valid, bus.Byte_Out); end
        if (bus.FOutN !== 1'b1)      begin errors++; $display("FAIL single_one_pulse: FOutN %b want 1", bus.FOutN); end
        cycles(8);
        checks += 4;
        if (capB.size() - m != 4) begin
            errors++; $display("FAIL single_count: got %0d bytes want 4", capB.size() - m);
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (capB[m+i] !== e[i] || capL[m+i] !== el[i] || capC[m+i] != capC[m] + i) begin
                    errors++;
                    $display("FAIL single_byte%0d: got %h last %b cyc+%0d want %h last %b cyc+%0d",
                             i, capB[m+i], capL[m+i], capC[m+i] - capC[m], e[i], el[i], i);
                end
            end
        end
        expWc++;
        if (popCnt - p != 1)   begin errors++; $display("FAIL single_pops: got %0d want 1", popCnt - p); end
        if (Word_Cnt !== 16'(expWc)) begin errors++; $display("FAIL single_wcnt: got %0d want %0d", Word_Cnt, expWc); end
        if (Busy !== 1'b0)     begin errors++; $display("FAIL single_busy: got %b want 0", Busy); end
    endtask

    task automatic test_back_to_back;
        int m = capB.size();
        int p = popCnt;
        int pl = popAtLast;
        push(32'h03020100); push(32'h07060504); push(32'h0B0A0908); push(32'h0F0E0D0C);
        cycles(22);
        checks += 4;
        if (capB.size() - m != 16) begin
            errors++; $display("FAIL b2b_count: got %0d bytes want 16", capB.size() - m);
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (capB[m+i] !== 8'(i) || capC[m+i] != capC[m] + i || capL[m+i] !== ((i % 4) == 3)) begin
                    errors++;
                    $display("FAIL b2b_byte%0d: got %h last %b cyc+%0d want %h cyc+%0d",
                             i, capB[m+i], capL[m+i], capC[m+i] - capC[m], 8'(i), i);
                end
            end
        end
        expWc += 4;
        if (popCnt - p != 4)      begin errors++; $display("FAIL b2b_pops: got %0d want 4", popCnt - p); end
        if (popAtLast - pl != 3)  begin errors++; $display("FAIL b2b_pop_at_last: got %0d want 3", popAtLast - pl); end
        if (Word_Cnt !== 16'(expWc)) begin errors++; $display("FAIL b2b_wcnt: got %0d want %0d", Word_Cnt, expWc); end
    endtask

    task automatic test_backpressure;
        int m = capB.size();
        int p = popCnt;
        push(32'h13121110); push(32'h17161514);
        wait_byte(8'h12, "bp_reach_idx2");
        bus.Byte_Ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge Clk);
            checks++;
            if (bus.Byte_Valid !== 1'b1 || bus.Byte_Out !== 8'h12 || bus.FOutN !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold%0d: valid %b byte %h foutn %b want 1 12 1",
                         k, bus.Byte_Valid, bus.Byte_Out, bus.FOutN);
            end
        end
        @(posedge Clk); #1;
        bus.Byte_Ready = 1'b1;
        cycles(12);
        checks += 3;
        if (capB.size() - m != 8) begin
            errors++; $display("FAIL bp_count: got %0d bytes want 8", capB.size() - m);
        end else begin
            for (int i = 0; i < 8; i++)
                if (capB[m+i] !== 8'h10 + 8'(i)) begin
                    errors++; $display("FAIL bp_byte%0d: got %h want %h", i, capB[m+i], 8'h10 + 8'(i));
                end
        end
        expWc += 2;
        if (popCnt - p != 2) begin errors++; $display("FAIL bp_pops: got %0d want 2", popCnt - p); end
        if (Word_Cnt !== 16'(expWc)) begin errors++; $display("FAIL bp_wcnt: got %0d want %0d", Word_Cnt, expWc); end
    endtask

    task automatic test_enable;
        logic [7:0] e [4] = '{8'h44, 8'h33, 8'h22, 8'h11};
        int m = capB.size();
        int p = popCnt;
        push(32'h11223344); push(32'h99887766);
        wait_byte(8'h33, "en_reach_idx1");
        Enable = 1'b0;
        cycles(8);
        checks += 4;
        if (capB.size() - m != 4) begin
            errors++; $display("FAIL en_count: got %0d bytes want 4", capB.size() - m);
        end else begin
            for (int i = 0; i < 4; i++)
                if (capB[m+i] !== e[i]) begin
                    errors++; $display("FAIL en_byte%0d: got %h want %h", i, capB[m+i], e[i]);
                end
        end
        expWc++;
        if (popCnt - p != 1) begin errors++; $display("FAIL en_pops: got %0d want 1", popCnt - p); end
        if (Busy !== 1'b0)   begin errors++; $display("FAIL en_busy: got %b want 0", Busy); end
        if (Word_Cnt !== 16'(expWc)) begin errors++; $display("FAIL en_wcnt: got %0d want %0d", Word_Cnt, expWc); end
        FClrN = 1'b0;
        cycles(1);
        FClrN = 1'b1;
        Enable = 1'b1;
        cycles(2);
    endtask

    task automatic test_clear;
        logic [7:0] e [7] = '{8'hEF, 8'hBE, 8'hAD, 8'h88, 8'h77, 8'h66, 8'h55};
        int m = capB.size();
        wait_byte(8'h00, "clr_dummy_skip") ; // idle bus presents 00 only when valid; see below
    endtask

    task automatic test_clear_word;
        logic [7:0] e [7] = '{8'hEF, 8'hBE, 8'hAD, 8'h88, 8'h77, 8'h66, 8'h55};
        int m = capB.size();
        push(32'hDEADBEEF);
        wait_byte(8'hAD, "clr_reach_idx2");
        FClrN = 1'b0;
        push(32'h01010101);
        @(negedge Clk);
        checks++;
        if (bus.FOutN !== 1'b1) begin errors++; $display("FAIL clr_foutn: got %b want 1", bus.FOutN); end
        @(posedge Clk); #1;
        FClrN = 1'b1;
        @(negedge Clk);
        checks += 2;
        if (bus.Byte_Valid !== 1'b0) begin errors++; $display("FAIL clr_valid: got %b want 0", bus.Byte_Valid); end
        if (Word_Cnt !== 16'(expWc)) begin errors++; $display("FAIL clr_wcnt: got %0d want %0d", Word_Cnt, expWc); end
        push(32'h55667788);
        cycles(10);
        checks += 2;
        if (capB.size() - m != 7) begin
            errors++; $display("FAIL clr_count: got %0d bytes want 7", capB.size() - m);
        end else begin
            for (int i = 0; i < 7; i++)
                if (capB[m+i] !== e[i]) begin
                    errors++; $display("FAIL clr_byte%0d: got %h want %h", i, capB[m+i], e[i]);
                end
        end
        expWc++;
        if (Word_Cnt !== 16'(expWc)) begin errors++; $display("FAIL clr_wcnt_after: got %0d want %0d", Word_Cnt, expWc); end
    endtask

    task automatic test_reset_mid_word;
        int m;
        int p;
        push(32'h04030201); push(32'h0D0C0B0A);
        wait_byte(8'h02, "rst_reach_idx1");
        RstN = 1'b0;
        #1;
        checks += 6;
        if (bus.FOutN !== 1'b1 || bus.F_EmptyN !== 1'b1)
            begin errors++; $display("FAIL rstm_foutn: FOutN %b emptyN %b want 1 1", bus.FOutN, bus.F_EmptyN); end
        if (bus.Byte_Valid !== 1'b0) begin errors++; $display("FAIL rstm_valid: got %b want 0", bus.Byte_Valid); end
        if (bus.Last_Byte !== 1'b0)  begin errors++; $display("FAIL rstm_last: got %b want 0", bus.Last_Byte); end
        if (Busy !== 1'b0)           begin errors++; $display("FAIL rstm_busy: got %b want 0", Busy); end
        if (bus.Byte_Out !== 8'h00)  begin errors++; $display("FAIL rstm_byte: got %h want 00", bus.Byte_Out); end
        if (Word_Cnt !== 16'd0)      begin errors++; $display("FAIL rstm_wcnt: got %0d want 0", Word_Cnt); end
        expWc = 0;
        @(posedge Clk); #1;
        m = capB.size();
        p = popCnt;
        RstN = 1'b1;
        cycles(12);
        checks += 3;
        if (capB.size() - m != 4) begin
            errors++; $display("FAIL rstm_count: got %0d bytes want 4", capB.size() - m);
        end else begin
            for (int i = 0; i < 4; i++)
                if (capB[m+i] !== 8'h0A + 8'(i)) begin
                    errors++; $display("FAIL rstm_byte%0d: got %h want %h", i, capB[m+i], 8'h0A + 8'(i));
                end
        end
        expWc++;
        if (popCnt - p != 1) begin errors++; $display("FAIL rstm_pops: got %0d want 1", popCnt - p); end
        if (Word_Cnt !== 16'(expWc)) begin errors++; $display("FAIL rstm_wcnt_after: got %0d want %0d", Word_Cnt, expWc); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_enable();
        test_clear_word();
        test_reset_mid_word();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
